// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: score width, class count,
// confidence threshold default and the output-stage state encoding.
package cnn_pkg;

    localparam int DW      = 16;
    localparam int N_CLASS = 10;
    localparam int IDX_W   = 4;

    localparam logic [DW-1:0] CONF_TH_DEF = 16'h0040;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [DW-1:0] score_t;

    // Running best and runner-up tracked by the argmax scan.
    typedef struct packed {
        score_t           max;
        score_t           sec;
        logic [IDX_W-1:0] cls;
    } best_t;

endpackage

// File: rtl/cls_argmax_if.sv
// Score inputs and classification results of the argmax stage.
interface cls_argmax_if;
    import cnn_pkg::*;

    logic       in_start;
    score_t     in_CLS_1;
    score_t     in_CLS_2;
    score_t     in_CLS_3;
    score_t     in_CLS_4;
    score_t     in_CLS_5;
    score_t     in_CLS_6;
    score_t     in_CLS_7;
    score_t     in_CLS_8;
    score_t     in_CLS_9;
    score_t     in_CLS_10;
    logic [3:0] out_class;
    score_t     out_max;
    score_t     out_margin;
    logic       out_low_conf;
    logic       out_valid;
    logic       out_busy;

    modport master (
        output in_start, in_CLS_1, in_CLS_2, in_CLS_3, in_CLS_4, in_CLS_5,
               in_CLS_6, in_CLS_7, in_CLS_8, in_CLS_9, in_CLS_10,
        input  out_class, out_max, out_margin, out_low_conf, out_valid, out_busy
    );

    modport slave (
        input  in_start, in_CLS_1, in_CLS_2, in_CLS_3, in_CLS_4, in_CLS_5,
               in_CLS_6, in_CLS_7, in_CLS_8, in_CLS_9, in_CLS_10,
        output out_class, out_max, out_margin, out_low_conf, out_valid, out_busy
    );

endinterface

// File: rtl/cls_cmp.sv
// One step of the argmax scan: fold score v at index idx into the running
// (max, sec, cls). Index 0 restarts the accumulation.
module cls_cmp
    import cnn_pkg::*;
(
    input  score_t           v,
    input  logic [IDX_W-1:0] idx,
    input  best_t            cur,
    output best_t            nxt
);

    always_comb begin
        nxt = cur;
        if (idx == '0) begin
            nxt.max = v;
            nxt.sec = '0;
            nxt.cls = '0;
        end else if (v > cur.max) begin
            nxt.sec = cur.max;
            nxt.max = v;
            nxt.cls = idx;
        end else if (v == cur.max) begin
            // Equal score: earliest class keeps the win, margin collapses to 0.
            nxt.sec = v;
        end else if (v > cur.sec) begin
            nxt.sec = v;
        end
    end

endmodule

// File: rtl/cls_argmax.sv
// Classification output stage: captures ten class scores on a start strobe,
// scans them one per cycle and holds winner, score, margin and confidence.
module cls_argmax
    import cnn_pkg::*;
#(
    parameter logic [DW-1:0] CONF_TH = CONF_TH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    cls_argmax_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    best_t            best_q, best_d, best_upd;
    score_t           buffer_q [N_CLASS];
    score_t           buffer_d [N_CLASS];
    score_t           in_scores [N_CLASS];
    score_t           scan_v;
    score_t           margin;
    logic             capture;

    logic [3:0]       out_class_q, out_class_d;
    score_t           out_max_q, out_max_d;
    score_t           out_margin_q, out_margin_d;
    logic             out_low_conf_q, out_low_conf_d;
    logic             out_valid_q, out_valid_d;

    assign in_scores[0] = bus.in_CLS_1;
    assign in_scores[1] = bus.in_CLS_2;
    assign in_scores[2] = bus.in_CLS_3;
    assign in_scores[3] = bus.in_CLS_4;
    assign in_scores[4] = bus.in_CLS_5;
    assign in_scores[5] = bus.in_CLS_6;
    assign in_scores[6] = bus.in_CLS_7;
    assign in_scores[7] = bus.in_CLS_8;
    assign in_scores[8] = bus.in_CLS_9;
    assign in_scores[9] = bus.in_CLS_10;

    // Inputs are only looked at on an accepted start; the scan runs from the copy.
    assign capture = (state_q == ST_IDLE) && bus.in_start;

    generate
        for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_buf
            assign buffer_d[gi] = capture ? in_scores[gi] : buffer_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CLASS; i++) begin
            if (!rst) buffer_q[i] <= '0;
            else      buffer_q[i] <= buffer_d[i];
        end
    end

    assign scan_v = buffer_q[idx_q];
    assign margin = best_q.max - best_q.sec;

    cls_cmp u_cmp (
        .v   (scan_v),
        .idx (idx_q),
        .cur (best_q),
        .nxt (best_upd)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        best_d         = best_q;
        out_class_d    = out_class_q;
        out_max_d      = out_max_q;
        out_margin_d   = out_margin_q;
        out_low_conf_d = out_low_conf_q;
        out_valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                best_d = best_upd;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_CLASS - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_class_d    = best_q.cls;
                out_max_d      = best_q.max;
                out_margin_d   = margin;
                out_low_conf_d = (margin < CONF_TH);
                out_valid_d    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            best_q         <= '0;
            out_class_q    <= '0;
            out_max_q      <= '0;
            out_margin_q   <= '0;
            out_low_conf_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            best_q         <= best_d;
            out_class_q    <= out_class_d;
            out_max_q      <= out_max_d;
            out_margin_q   <= out_margin_d;
            out_low_conf_q <= out_low_conf_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign bus.out_class    = out_class_q;
    assign bus.out_max      = out_max_q;
    assign bus.out_margin   = out_margin_q;
    assign bus.out_low_conf = out_low_conf_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cls_argmax.sv
// Directed bench for cls_argmax: hand-computed winners, latency, restart and
// mid-scan reset behaviour.
module tb_cls_argmax;
    import cnn_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   t0;
    int   t1;
    bit   got;
    int   vcount;
    score_t vec [N_CLASS];

    cls_argmax_if u_if ();

    cls_argmax u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic drive_vec();
        u_if.in_CLS_1  = vec[0];
        u_if.in_CLS_2  = vec[1];
        u_if.in_CLS_3  = vec[2];
        u_if.in_CLS_4  = vec[3];
        u_if.in_CLS_5  = vec[4];
        u_if.in_CLS_6  = vec[5];
        u_if.in_CLS_7  = vec[6];
        u_if.in_CLS_8  = vec[7];
        u_if.in_CLS_9  = vec[8];
        u_if.in_CLS_10 = vec[9];
    endtask

    // Called at a negedge; E0 is the following posedge. Returns at the negedge after E0.
    task automatic pulse_start();
        drive_vec();
        u_if.in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_valid(input string tag);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (u_if.out_valid) got = 1'b1;
        end
        t1 = cyc;
        if (!got) chk({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [3:0] e_cls,
                                input score_t e_max, input score_t e_mar, input logic e_low);
        chk({tag, "_latency"}, 32'(t1 - t0), 32'd11);
        chk({tag, "_class"},   32'(u_if.out_class), 32'(e_cls));
        chk({tag, "_max"},     32'(u_if.out_max), 32'(e_max));
        chk({tag, "_margin"},  32'(u_if.out_margin), 32'(e_mar));
        chk({tag, "_lowconf"}, 32'(u_if.out_low_conf), 32'(e_low));
        chk({tag, "_busy_off"}, 32'(u_if.out_busy), 32'd0);
    endtask

    task automatic vec_ramp();
        for (int i = 0; i < N_CLASS; i++) vec[i] = score_t'((i + 1) * 10);
    endtask

    task automatic vec_two_peaks();
        for (int i = 0; i < N_CLASS; i++) vec[i] = '0;
        vec[3] = 16'h0400;
        vec[7] = 16'h0100;
    endtask

    task automatic vec_tie();
        for (int i = 0; i < N_CLASS; i++) vec[i] = '0;
        vec[2] = 16'h0200;
        vec[5] = 16'h0200;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b0;
        u_if.in_start = 1'b0;
        for (int i = 0; i < N_CLASS; i++) vec[i] = '0;
        drive_vec();

        // Reset, then idle with no start
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (u_if.out_valid) vcount++;
        end
        chk("idle_valid_count", 32'(vcount), 32'd0);
        chk("idle_class",   32'(u_if.out_class), 32'd0);
        chk("idle_max",     32'(u_if.out_max), 32'd0);
        chk("idle_margin",  32'(u_if.out_margin), 32'd0);
        chk("idle_lowconf", 32'(u_if.out_low_conf), 32'd0);
        chk("idle_busy",    32'(u_if.out_busy), 32'd0);

        // Ascending scores: class 9 wins by 10
        vec_ramp();
        pulse_start();
        chk("ramp_busy_on", 32'(u_if.out_busy), 32'd1);
        wait_valid("ramp");
        check_result("ramp", 4'd9, 16'd100, 16'd10, 1'b1);

        // Two peaks, confident
        @(negedge clk);
        vec_two_peaks();
        pulse_start();
        wait_valid("peaks");
        check_result("peaks", 4'd3, 16'h0400, 16'h0300, 1'b0);

        // Tie: lowest index wins
        @(negedge clk);
        vec_tie();
        pulse_start();
        wait_valid("tie");
        check_result("tie", 4'd2, 16'h0200, 16'h0000, 1'b1);

        // Start during SCAN is ignored
        @(negedge clk);
        vec_two_peaks();
        pulse_start();
        repeat (3) @(negedge clk);
        vec_ramp();
        drive_vec();
        u_if.in_start = 1'b1;
        @(negedge clk);
        u_if.in_start = 1'b0;
        wait_valid("ignore");
        check_result("ignore", 4'd3, 16'h0400, 16'h0300, 1'b0);

        // Start in the out_valid cycle is accepted
        vec_ramp();
        pulse_start();
        wait_valid("b2b");
        check_result("b2b", 4'd9, 16'd100, 16'd10, 1'b1);

        // Reset during the fifth SCAN cycle
        @(negedge clk);
        vec_two_peaks();
        pulse_start();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_class",   32'(u_if.out_class), 32'd0);
        chk("rst_max",     32'(u_if.out_max), 32'd0);
        chk("rst_margin",  32'(u_if.out_margin), 32'd0);
        chk("rst_lowconf", 32'(u_if.out_low_conf), 32'd0);
        chk("rst_busy",    32'(u_if.out_busy), 32'd0);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (u_if.out_valid) vcount++;
        end
        chk("rst_valid_count", 32'(vcount), 32'd0);

        vec_tie();
        pulse_start();
        wait_valid("post_rst");
        check_result("post_rst", 4'd2, 16'h0200, 16'h0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cls_argmax.md
# cls_argmax

Classification output stage directly downstream of the second fully connected layer. It captures the ten 16-bit class scores on a start strobe. It scans them sequentially, one per cycle, and reports the winning class index, its score, the margin over the runner-up, and a low-confidence flag. Results are held until the next completed scan for board display and host readout.

## Interface
Parameters:
- N_CLASS, 10, number of class scores (fixed at 10 by the port list)
- DW, 16, score width, unsigned Q-format as produced by the FC layer after ReLU
- CONF_TH, 16'h0040, margin below which out_low_conf is raised

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets on the clock edge)
- in_start  input  1  one-cycle strobe: scores on in_CLS_* are valid this cycle
- in_CLS_1 … in_CLS_10  input  16 each  class scores, class 0 … class 9
- out_class  output  4  index (0–9) of the maximum score
- out_max  output  16  maximum score
- out_margin  output  16  out_max minus second-highest score
- out_low_conf  output  1  1 when out_margin < CONF_TH
- out_valid  output  1  one-cycle pulse: results updated this cycle
- out_busy  output  1  1 while a capture/scan is in progress

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: on in_start==1, copy all ten inputs into a score buffer. Clear idx to 0 and go to SCAN. Inputs are not sampled again until the next accepted start.
- SCAN: each cycle, process buffer[idx] against the running best (max, cls) and runner-up (sec):
  - idx==0: max=v, cls=0, sec=0.
  - v > max: sec=max, max=v, cls=idx.
  - else if v > sec: sec=v.
  - Tie v==max with idx>0: cls unchanged (lowest index wins), sec=v.
  - idx increments; after idx==9 is processed, go to DONE.
- DONE: register out_class=cls, out_max=max, out_margin=max−sec, and out_low_conf=(margin<CONF_TH). Pulse out_valid and return to IDLE.
- Arithmetic: unsigned compares on full 16 bits. The margin cannot underflow because sec ≤ max. No saturation is needed.
- in_start while in SCAN or DONE is ignored (not queued).
- Outputs other than out_valid/out_busy hold their last results until the next DONE.
- Reset (any state, including mid-scan) aborts the operation. All outputs become 0, the state goes to IDLE, idx=0, and the buffer is cleared.

## Timing
- Edge E0 samples in_start in IDLE and captures scores; out_busy=1 from after E0.
- Edges E1–E10 process indices 0–9.
- Edge E11 is in DONE and updates results; out_valid=1 and out_busy=0 during the cycle after E11.
- Latency: 11 clocks from the start-sampling edge to results. The earliest next accepted start is sampled at E12 (out_valid==1 and in_start==1 in the same cycle is accepted).
- Throughput: one classification per 12 cycles maximum.
- Reset values: out_class=0, out_max=0, out_margin=0, out_low_conf=0, out_valid=0, out_busy=0.

## Structure
- Shared package cnn_pkg holds DW, N_CLASS, CONF_TH default, and the state enumeration (IDLE/SCAN/DONE). Other CNN stages reuse these.
- One sub-module is natural: cls_cmp, a combinational update of (max, sec, cls) from (v, idx). The top level holds the FSM, buffer, idx counter, and output registers.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then 1 with no start -> all outputs 0, out_valid never asserts.
- Distinct scores 10,20,30,…,100 (class 9 highest), start pulse -> out_valid exactly 11 cycles after start edge; out_class=9, out_max=100, out_margin=10, out_low_conf=1.
- Scores all 0 except class 3=16'h0400, class 7=16'h0100 -> out_class=3, out_max=16'h0400, out_margin=16'h0300, out_low_conf=0.
- Tie: class 2 and class 5 both 16'h0200, others 0 -> out_class=2, out_margin=0, out_low_conf=1.
- Start re-asserted during SCAN with different scores -> ignored, results match the first capture. A start in the out_valid cycle is accepted and its result appears 11 cycles later.
- rst=0 asserted at the fifth SCAN cycle -> next cycle all outputs 0, out_busy=0, no out_valid. A subsequent start produces correct results.
